prbs8_check: RTL and testbench
==============================

PRBS8_CHECK -- requirements
Module: prbs8_check

Interface
REQ-001 Parameter LOCK_GOOD, default 16, is the number of consecutive correct predictions required to declare lock.
REQ-002 Parameter LOSS_ERRS, default 4, is the number of errors inside one loss window that drops lock.
REQ-003 Parameter LOSS_WIN, default 32, is the loss window length in valid bits.
REQ-004 CLK  input  1  is the single clock; all state is updated on its rising edge.
REQ-005 RESET  input  1  is a synchronous, active-high reset.
REQ-006 DIN  input  1  is the received bit from the 8-bit PRBS generator's serial output, with the generator enable held high.
REQ-007 DIN_VALID  input  1  qualifies DIN; DIN is sampled only when DIN_VALID=1.
REQ-008 CLEAR_ERR  input  1  is a synchronous clear of ERR_COUNT and LOSS_COUNT.
REQ-009 LOCKED  output  1  is high while the checker is in state LOCKED.
REQ-010 ERR_PULSE  output  1  is a registered one-cycle pulse for each mismatch detected in LOCKED.
REQ-011 ERR_COUNT  output  16  counts bit errors in LOCKED and saturates at 0xFFFF.
REQ-012 LOSS_COUNT  output  8  counts LOCKED->SEARCH transitions and saturates at 0xFF.

Function
REQ-013 Stream model: b[k] = b[k-1] ^ b[k-3] ^ b[k-5] ^ b[k-8], period 255; an all-zero 8-bit window never occurs in a valid stream.
REQ-014 History register H[7:0] holds the 8 most recent valid bits (H[0] is newest); prediction P = H[0]^H[2]^H[4]^H[7].
REQ-015 All state advances only on cycles with DIN_VALID=1, except RESET and CLEAR_ERR, which act on any cycle.
REQ-016 FSM states are SEARCH, CHECK and LOCKED.
REQ-017 SEARCH: shift DIN into H and count fill; after the 8th valid bit, go to CHECK with the good counter at 0.
REQ-018 CHECK, match (DIN==P) with H!=0: increment the good counter; reaching LOCK_GOOD moves to LOCKED on the same edge.
REQ-019 CHECK, mismatch or H==0: clear the good counter and remain in CHECK; H still shifts in DIN (self-resync).
REQ-020 LOCKED: shift P into H (flywheel) rather than DIN, so a single DIN error counts exactly once.
REQ-021 LOCKED, mismatch: ERR_PULSE=1 for the next cycle, ERR_COUNT+1 (saturating), window error counter +1.
REQ-022 Loss window: a counter counts valid bits in LOCKED; after LOSS_WIN bits, both it and the window error counter restart at 0.
REQ-023 When the window error counter reaches LOSS_ERRS: go to SEARCH, clear fill/good/window counters, and increment LOSS_COUNT (saturating).
REQ-024 The error that triggers a loss of lock is itself counted in ERR_COUNT.
REQ-025 Latency: LOCKED rises on the edge that samples the (8+LOCK_GOOD)th consecutive good valid bit; ERR_PULSE appears 1 cycle after the erroneous bit is sampled.
REQ-026 CLEAR_ERR coincident with an error: the clear wins and ERR_COUNT=0; lock state is unaffected.
REQ-027 Saturation: counters hold at their maximum value and do not wrap.

Reset
REQ-028 RESET=1 forces SEARCH, H=0, all internal counters 0, LOCKED=0, ERR_PULSE=0, ERR_COUNT=0, LOSS_COUNT=0.
REQ-029 RESET overrides DIN_VALID and CLEAR_ERR; reset applied mid-LOCKED behaves identically to reset from power-up.
REQ-030 The first valid bit after RESET deasserts is sampled as fill bit 1.

Verification
REQ-031 Generator from its reset state (first bits 0,1,1,1,0,...), DIN_VALID=1 continuously -> LOCKED=1 after the 24th bit, ERR_COUNT=0 over 1000 bits.
REQ-032 Locked stream with bit 100 inverted -> exactly one ERR_PULSE, ERR_COUNT=1, LOCKED stays 1, no further errors.
REQ-033 Locked stream with 4 inverted bits within 32 bits -> LOCKED=0 on the 4th error, ERR_COUNT=4, LOSS_COUNT=1, then relock 24 bits later.
REQ-034 Constant DIN=0 -> never locks; LOCKED=0, ERR_COUNT=0 indefinitely.
REQ-035 DIN_VALID toggling 1-0-1 with the stream presented on valid cycles only -> same lock point in valid-bit count as REQ-031; invalid cycles ignored.
REQ-036 CLEAR_ERR on the same cycle as an error, and RESET asserted mid-LOCKED -> ERR_COUNT=0 next cycle; after reset, all outputs are 0 and the FSM is in SEARCH.

Source files
------------

// File: rtl/prbs8_check.sv
// rtl/prbs8_check.sv - PRBS8 serial checker with search/check/locked FSM, error and loss-of-lock counters
module prbs8_check #(
    parameter int LOCK_GOOD = 16,
    parameter int LOSS_ERRS = 4,
    parameter int LOSS_WIN  = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        DIN,
    input  logic        DIN_VALID,
    input  logic        CLEAR_ERR,
    output logic        LOCKED,
    output logic        ERR_PULSE,
    output logic [15:0] ERR_COUNT,
    output logic [7:0]  LOSS_COUNT
);

    localparam int GW = $clog2(LOCK_GOOD + 1);
    localparam int WW = $clog2(LOSS_WIN + 1);
    localparam int EW = $clog2(LOSS_ERRS + 1);

    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_GOOD);
    localparam logic [WW-1:0] WIN_LAST = WW'(LOSS_WIN - 1);
    localparam logic [EW-1:0] ERRS_MAX = EW'(LOSS_ERRS);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    h_q, h_d;
    logic [2:0]    fill_q, fill_d;
    logic [GW-1:0] good_q, good_d;
    logic [WW-1:0] win_bits_q, win_bits_d;
    logic [EW-1:0] win_err_q, win_err_d;
    logic          err_pulse_q, err_pulse_d;
    logic [15:0]   err_count_q, err_count_d;
    logic [7:0]    loss_count_q, loss_count_d;

    logic          pred;
    logic          mismatch;
    logic [EW-1:0] win_err_sum;

    always_comb begin
        state_d      = state_q;
        h_d          = h_q;
        fill_d       = fill_q;
        good_d       = good_q;
        win_bits_d   = win_bits_q;
        win_err_d    = win_err_q;
        err_pulse_d  = 1'b0;
        err_count_d  = err_count_q;
        loss_count_d = loss_count_q;

        pred        = h_q[0] ^ h_q[2] ^ h_q[4] ^ h_q[7];
        mismatch    = DIN ^ pred;
        win_err_sum = win_err_q + EW'(mismatch);

        if (DIN_VALID) begin
            case (state_q)
                ST_SEARCH: begin
                    h_d = {h_q[6:0], DIN};
                    if (fill_q == 3'd7) begin
                        fill_d  = 3'd0;
                        good_d  = '0;
                        state_d = ST_CHECK;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end
                ST_CHECK: begin
                    // Keep shifting raw DIN so a bad history flushes itself out
                    h_d = {h_q[6:0], DIN};
                    if (!mismatch && (h_q != 8'd0)) begin
                        if (good_q + GW'(1) == GOOD_MAX) begin
                            good_d     = '0;
                            win_bits_d = '0;
                            win_err_d  = '0;
                            state_d    = ST_LOCKED;
                        end else begin
                            good_d = good_q + GW'(1);
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel on the prediction so one bad DIN bit costs one error
                    h_d = {h_q[6:0], pred};
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != 16'hFFFF) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                    end
                    if (win_err_sum == ERRS_MAX) begin
                        state_d    = ST_SEARCH;
                        fill_d     = 3'd0;
                        good_d     = '0;
                        win_bits_d = '0;
                        win_err_d  = '0;
                        if (loss_count_q != 8'hFF) begin
                            loss_count_d = loss_count_q + 8'd1;
                        end
                    end else if (win_bits_q == WIN_LAST) begin
                        win_bits_d = '0;
                        win_err_d  = '0;
                    end else begin
                        win_bits_d = win_bits_q + WW'(1);
                        win_err_d  = win_err_sum;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end

        if (CLEAR_ERR) begin
            err_count_d  = 16'd0;
            loss_count_d = 8'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_SEARCH;
            h_q          <= 8'd0;
            fill_q       <= 3'd0;
            good_q       <= '0;
            win_bits_q   <= '0;
            win_err_q    <= '0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= 16'd0;
            loss_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            fill_q       <= fill_d;
            good_q       <= good_d;
            win_bits_q   <= win_bits_d;
            win_err_q    <= win_err_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
            loss_count_q <= loss_count_d;
        end
    end

    assign LOCKED     = (state_q == ST_LOCKED);
    assign ERR_PULSE  = err_pulse_q;
    assign ERR_COUNT  = err_count_q;
    assign LOSS_COUNT = loss_count_q;

endmodule

// File: tb/tb_prbs8_check.sv
// tb/tb_prbs8_check.sv - directed self-checking bench for prbs8_check
module tb_prbs8_check;

    logic        CLK;
    logic        RESET;
    logic        DIN;
    logic        DIN_VALID;
    logic        CLEAR_ERR;
    logic        LOCKED;
    logic        ERR_PULSE;
    logic [15:0] ERR_COUNT;
    logic [7:0]  LOSS_COUNT;

    int n_checks;
    int n_fail;
    int sidx;
    int pulse_cnt;
    logic stream [0:8191];

    prbs8_check dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .DIN        (DIN),
        .DIN_VALID  (DIN_VALID),
        .CLEAR_ERR  (CLEAR_ERR),
        .LOCKED     (LOCKED),
        .ERR_PULSE  (ERR_PULSE),
        .ERR_COUNT  (ERR_COUNT),
        .LOSS_COUNT (LOSS_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after the edge; outputs are read at the same point
    task automatic step(input logic d, input logic v, input logic clr);
        DIN       = d;
        DIN_VALID = v;
        CLEAR_ERR = clr;
        @(posedge CLK);
        #1;
        if (ERR_PULSE === 1'b1) pulse_cnt++;
    endtask

    task automatic send(input logic inv, input logic clr);
        step(stream[sidx] ^ inv, 1'b1, clr);
        sidx++;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        RESET     = 1'b0;
        sidx      = 0;
        pulse_cnt = 0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        n_checks++; if (LOCKED !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", LOCKED); end
        n_checks++; if (ERR_PULSE !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse: got %b want 0", ERR_PULSE); end
        n_checks++; if (ERR_COUNT !== 16'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", ERR_COUNT); end
        n_checks++; if (LOSS_COUNT !== 8'd0) begin n_fail++; $display("FAIL reset_loss_count: got %0d want 0", LOSS_COUNT); end
        RESET     = 1'b0;
        sidx      = 0;
        pulse_cnt = 0;
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 1; i <= 23; i++) send(1'b0, 1'b0);
        n_checks++; if (LOCKED !== 1'b0) begin n_fail++; $display("FAIL lock_before_24: got %b want 0", LOCKED); end
        send(1'b0, 1'b0);
        n_checks++; if (LOCKED !== 1'b1) begin n_fail++; $display("FAIL lock_at_24: got %b want 1", LOCKED); end
        for (int i = 25; i <= 1000; i++) send(1'b0, 1'b0);
        n_checks++; if (LOCKED !== 1'b1) begin n_fail++; $display("FAIL lock_hold_1000: got %b want 1", LOCKED); end
        n_checks++; if (ERR_COUNT !== 16'd0) begin n_fail++; $display("FAIL lock_err_count: got %0d want 0", ERR_COUNT); end
        n_checks++; if (pulse_cnt != 0) begin n_fail++; $display("FAIL lock_pulses: got %0d want 0", pulse_cnt); end
    endtask

    task automatic test_single_error();
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            send(i == 100, 1'b0);
            if (i == 100) begin
                n_checks++; if (ERR_PULSE !== 1'b1) begin n_fail++; $display("FAIL single_pulse_high: got %b want 1", ERR_PULSE); end
                n_checks++; if (ERR_COUNT !== 16'd1) begin n_fail++; $display("FAIL single_count_at_err: got %0d want 1", ERR_COUNT); end
            end
            if (i == 101) begin
                n_checks++; if (ERR_PULSE !== 1'b0) begin n_fail++; $display("FAIL single_pulse_low: got %b want 0", ERR_PULSE); end
            end
        end
        n_checks++; if (pulse_cnt != 1) begin n_fail++; $display("FAIL single_pulses: got %0d want 1", pulse_cnt); end
        n_checks++; if (ERR_COUNT !== 16'd1) begin n_fail++; $display("FAIL single_err_count: got %0d want 1", ERR_COUNT); end
        n_checks++; if (LOCKED !== 1'b1) begin n_fail++; $display("FAIL single_locked: got %b want 1", LOCKED); end
    endtask

    task automatic test_window_boundary();
        // 3 errors end window 1 at bit 56, 3 more start window 2 at bit 57
        do_reset();
        for (int i = 1; i <= 150; i++)
            send((i == 30) || (i == 40) || (i == 56) || (i == 57) || (i == 60) || (i == 70), 1'b0);
        n_checks++; if (LOCKED !== 1'b1) begin n_fail++; $display("FAIL window_locked: got %b want 1", LOCKED); end
        n_checks++; if (ERR_COUNT !== 16'd6) begin n_fail++; $display("FAIL window_err_count: got %0d want 6", ERR_COUNT); end
        n_checks++; if (LOSS_COUNT !== 8'd0) begin n_fail++; $display("FAIL window_loss_count: got %0d want 0", LOSS_COUNT); end
    endtask

    task automatic test_loss();
        do_reset();
        for (int i = 1; i <= 200; i++) begin
            send((i == 40) || (i == 42) || (i == 44) || (i == 46), 1'b0);
            if (i == 44) begin
                n_checks++; if (LOCKED !== 1'b1) begin n_fail++; $display("FAIL loss_third_locked: got %b want 1", LOCKED); end
                n_checks++; if (ERR_COUNT !== 16'd3) begin n_fail++; $display("FAIL loss_third_count: got %0d want 3", ERR_COUNT); end
            end
            if (i == 46) begin
                n_checks++; if (LOCKED !== 1'b0) begin n_fail++; $display("FAIL loss_fourth_locked: got %b want 0", LOCKED); end
                n_checks++; if (ERR_COUNT !== 16'd4) begin n_fail++; $display("FAIL loss_fourth_count: got %0d want 4", ERR_COUNT); end
                n_checks++; if (LOSS_COUNT !== 8'd1) begin n_fail++; $display("FAIL loss_count: got %0d want 1", LOSS_COUNT); end
            end
            if (i == 69) begin
                n_checks++; if (LOCKED !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %b want 0", LOCKED); end
            end
            if (i == 70) begin
                n_checks++; if (LOCKED !== 1'b1) begin n_fail++; $display("FAIL relock_at_70: got %b want 1", LOCKED); end
            end
        end
        n_checks++; if (ERR_COUNT !== 16'd4) begin n_fail++; $display("FAIL loss_final_count: got %0d want 4", ERR_COUNT); end
        n_checks++; if (LOSS_COUNT !== 8'd1) begin n_fail++; $display("FAIL loss_final_loss: got %0d want 1", LOSS_COUNT); end
    endtask

    task automatic test_zero();
        int seen_lock;
        seen_lock = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (LOCKED !== 1'b0) seen_lock++;
        end
        n_checks++; if (seen_lock != 0) begin n_fail++; $display("FAIL zero_locked_cycles: got %0d want 0", seen_lock); end
        n_checks++; if (ERR_COUNT !== 16'd0) begin n_fail++; $display("FAIL zero_err_count: got %0d want 0", ERR_COUNT); end
    endtask

    task automatic test_valid_toggle();
        do_reset();
        for (int v = 1; v <= 224; v++) begin
            send(1'b0, 1'b0);
            step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (v == 23) begin
                n_checks++; if (LOCKED !== 1'b0) begin n_fail++; $display("FAIL toggle_before_24: got %b want 0", LOCKED); end
            end
            if (v == 24) begin
                n_checks++; if (LOCKED !== 1'b1) begin n_fail++; $display("FAIL toggle_at_24: got %b want 1", LOCKED); end
            end
        end
        n_checks++; if (ERR_COUNT !== 16'd0) begin n_fail++; $display("FAIL toggle_err_count: got %0d want 0", ERR_COUNT); end
        n_checks++; if (LOCKED !== 1'b1) begin n_fail++; $display("FAIL toggle_final_locked: got %b want 1", LOCKED); end
    endtask

    task automatic test_clear_and_reset();
        do_reset();
        for (int i = 1; i <= 60; i++) begin
            send((i == 40) || (i == 50), i == 50);
            if (i == 40) begin
                n_checks++; if (ERR_COUNT !== 16'd1) begin n_fail++; $display("FAIL clear_pre_count: got %0d want 1", ERR_COUNT); end
            end
            if (i == 50) begin
                n_checks++; if (ERR_COUNT !== 16'd0) begin n_fail++; $display("FAIL clear_wins: got %0d want 0", ERR_COUNT); end
                n_checks++; if (ERR_PULSE !== 1'b1) begin n_fail++; $display("FAIL clear_pulse: got %b want 1", ERR_PULSE); end
                n_checks++; if (LOCKED !== 1'b1) begin n_fail++; $display("FAIL clear_locked: got %b want 1", LOCKED); end
            end
        end
        send(1'b1, 1'b0);
        n_checks++; if (ERR_COUNT !== 16'd1) begin n_fail++; $display("FAIL clear_post_count: got %0d want 1", ERR_COUNT); end
        RESET = 1'b1;
        send(1'b1, 1'b1);
        n_checks++; if ({LOCKED, ERR_PULSE} !== 2'b00) begin n_fail++; $display("FAIL midreset_flags: got %b want 00", {LOCKED, ERR_PULSE}); end
        n_checks++; if (ERR_COUNT !== 16'd0) begin n_fail++; $display("FAIL midreset_err_count: got %0d want 0", ERR_COUNT); end
        n_checks++; if (LOSS_COUNT !== 8'd0) begin n_fail++; $display("FAIL midreset_loss_count: got %0d want 0", LOSS_COUNT); end
        RESET = 1'b0;
        sidx  = 0;
        for (int i = 1; i <= 23; i++) send(1'b0, 1'b0);
        n_checks++; if (LOCKED !== 1'b0) begin n_fail++; $display("FAIL midreset_relock_early: got %b want 0", LOCKED); end
        send(1'b0, 1'b0);
        n_checks++; if (LOCKED !== 1'b1) begin n_fail++; $display("FAIL midreset_relock_24: got %b want 1", LOCKED); end
    endtask

    task automatic test_loss_saturation();
        int lock_miss;
        lock_miss = 0;
        do_reset();
        for (int n = 1; n <= 256; n++) begin
            for (int i = 0; i < 24; i++) send(1'b0, 1'b0);
            if (LOCKED !== 1'b1) lock_miss++;
            for (int i = 0; i < 4; i++) send(1'b1, 1'b0);
            if (n == 255) begin
                n_checks++; if (LOSS_COUNT !== 8'd255) begin n_fail++; $display("FAIL sat_loss_255: got %0d want 255", LOSS_COUNT); end
            end
        end
        n_checks++; if (lock_miss != 0) begin n_fail++; $display("FAIL sat_relock_misses: got %0d want 0", lock_miss); end
        n_checks++; if (LOSS_COUNT !== 8'd255) begin n_fail++; $display("FAIL sat_loss_hold: got %0d want 255", LOSS_COUNT); end
        n_checks++; if (ERR_COUNT !== 16'd1024) begin n_fail++; $display("FAIL sat_err_count: got %0d want 1024", ERR_COUNT); end
        n_checks++; if (LOCKED !== 1'b0) begin n_fail++; $display("FAIL sat_locked: got %b want 0", LOCKED); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        sidx      = 0;
        pulse_cnt = 0;
        RESET     = 1'b1;
        DIN       = 1'b0;
        DIN_VALID = 1'b0;
        CLEAR_ERR = 1'b0;

        // Generator output starting 0,1,1,1,0 then following b[k]=b[k-1]^b[k-3]^b[k-5]^b[k-8]
        stream[0] = 1'b0; stream[1] = 1'b1; stream[2] = 1'b1; stream[3] = 1'b1;
        stream[4] = 1'b0; stream[5] = 1'b0; stream[6] = 1'b1; stream[7] = 1'b0;
        for (int k = 8; k < 8192; k++)
            stream[k] = stream[k-1] ^ stream[k-3] ^ stream[k-5] ^ stream[k-8];

        test_reset();
        test_lock();
        test_single_error();
        test_window_boundary();
        test_loss();
        test_zero();
        test_valid_toggle();
        test_clear_and_reset();
        test_loss_saturation();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
